// File: rtl/dsp48a1_mac_sequencer.sv
// Controller that streams operand pairs into a DSP48A1-style slice and returns the
// accumulated P. OPMODE follows a tag line that tracks each term through the slice pipeline.
module dsp48a1_mac_sequencer #(
  parameter int DATA_W   = 18,
  parameter int ACC_W    = 48,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  output logic [DATA_W-1:0] dsp_a,
  output logic [DATA_W-1:0] dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_ce,
  input  logic [ACC_W-1:0]  dsp_p,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_result,
  output logic              busy
);

  localparam int TAG_DEPTH = 1 + PIPE_LAT;

  localparam logic [7:0] OP_IDLE = 8'h00;
  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_ACC  = 8'h09;
  localparam logic [7:0] OP_HOLD = 8'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [LEN_W-1:0]     remaining;
  logic                 first_pending;
  logic [TAG_DEPTH-1:0] tag_valid;
  logic [TAG_DEPTH-1:0] tag_first;
  logic                 take;
  logic                 accept_start;
  logic                 tag_empty;
  logic                 capture;

  assign take         = (state == ACCUM) && s_valid;
  assign accept_start = (state == IDLE) && start && (len != '0);
  assign tag_empty    = (tag_valid == '0);
  // Once the line is empty the last product has already been folded into P.
  assign capture      = (state == DRAIN) && tag_empty;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    dsp_ce     = 1'b0;
    m_valid    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept_start) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        s_ready = 1'b1;
        dsp_ce  = 1'b1;
        if (take && (remaining == LEN_W'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        dsp_ce = 1'b1;
        if (tag_empty) begin
          state_next = DONE;
        end
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tag line: one entry per busy cycle, bubbles carry valid=0.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_first <= '0;
    end else if (state != IDLE) begin
      tag_valid <= {tag_valid[TAG_DEPTH-2:0], take};
      tag_first <= {tag_first[TAG_DEPTH-2:0], take && first_pending};
    end
  end

  always_comb begin
    dsp_opmode = OP_IDLE;
    if (state != IDLE) begin
      if (!tag_valid[TAG_DEPTH-1]) begin
        dsp_opmode = OP_HOLD;
      end else if (tag_first[TAG_DEPTH-1]) begin
        dsp_opmode = OP_LOAD;
      end else begin
        dsp_opmode = OP_ACC;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      remaining     <= '0;
      first_pending <= 1'b0;
      dsp_a         <= '0;
      dsp_b         <= '0;
      m_result      <= '0;
    end else begin
      if (accept_start) begin
        remaining     <= len;
        first_pending <= 1'b1;
      end else if (take) begin
        remaining     <= remaining - LEN_W'(1);
        first_pending <= 1'b0;
      end
      if (take) begin
        dsp_a <= s_a;
        dsp_b <= s_b;
      end
      if (capture) begin
        m_result <= dsp_p;
      end
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: a behavioural slice supplies dsp_p, and every block
// result is compared with the plain sum of products computed by the bench.
module tb_dsp48a1_mac_sequencer;

  localparam int DATA_W   = 18;
  localparam int ACC_W    = 48;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;

  logic              CLK = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_a = '0;
  logic [DATA_W-1:0] s_b = '0;
  logic [DATA_W-1:0] dsp_a;
  logic [DATA_W-1:0] dsp_b;
  logic [7:0]        dsp_opmode;
  logic              dsp_ce;
  logic [ACC_W-1:0]  dsp_p;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [ACC_W-1:0]  m_result;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int op_a [64];
  int op_b [64];
  logic [DATA_W-1:0] last_a = '0;
  logic [DATA_W-1:0] last_b = '0;
  logic [7:0] op_trace [$];
  bit tracing = 1'b0;

  always #5 CLK = ~CLK;

  dsp48a1_mac_sequencer #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .len(len),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_p(dsp_p), .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
    .busy(busy)
  );

  // Behavioural slice: PIPE_LAT product stages, then X/Z post-adder into P (never reset).
  logic signed [2*DATA_W-1:0] prod_pipe [PIPE_LAT];
  logic [ACC_W-1:0] p_reg = 48'h5A5A_0F0F_1234;
  logic [ACC_W-1:0] m_ext;
  logic [ACC_W-1:0] x_mux;
  logic [ACC_W-1:0] z_mux;

  assign m_ext = ACC_W'(prod_pipe[PIPE_LAT-1]);
  assign dsp_p = p_reg;

  always_comb begin
    x_mux = '1;
    z_mux = '1;
    case (dsp_opmode[1:0])
      2'd0: x_mux = '0;
      2'd1: x_mux = m_ext;
      default: x_mux = '1;
    endcase
    case (dsp_opmode[3:2])
      2'd0: z_mux = '0;
      2'd2: z_mux = p_reg;
      default: z_mux = '1;
    endcase
  end

  always @(posedge CLK) begin
    if (dsp_ce) begin
      prod_pipe[0] <= $signed(dsp_a) * $signed(dsp_b);
      for (int i = 1; i < PIPE_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
      p_reg <= z_mux + x_mux;
    end
  end

  always @(negedge CLK) begin
    if (tracing && dsp_ce) op_trace.push_back(dsp_opmode);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string expv);
    checks++;
    assert (obs == expv) else begin
      failures++;
      $error("FAIL %s observed=[%s] expected=[%s]", tag, obs, expv);
    end
  endtask

  // Opcode list with the leading/trailing hold cycles removed.
  function automatic string op_seq(input logic [7:0] q_in [$]);
    logic [7:0] q [$];
    string s;
    q = q_in;
    s = "";
    while (q.size() > 0 && q[0] == 8'h08) void'(q.pop_front());
    while (q.size() > 0 && q[q.size()-1] == 8'h08) void'(q.pop_back());
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic run_block(input int n, input int gap_at, input int gap_len, input int hold,
                           input bit rnd, input bit mid_start);
    logic [ACC_W-1:0] expv;
    logic [7:0] exp_ops [$];
    int idx, cyc, bubbles, fixed_gaps;
    bit first, timeout, bub;
    expv = '0;
    for (int i = 0; i < n; i++) expv = expv + ACC_W'(longint'(op_a[i]) * longint'(op_b[i]));
    @(posedge CLK); #1;
    op_trace.delete();
    tracing = 1'b1;
    start = 1'b1;
    len = LEN_W'(n);
    cyc = 0;
    @(posedge CLK); #1;
    cyc = 1;
    start = 1'b0;
    idx = 0; bubbles = 0; fixed_gaps = 0; first = 1'b1;
    while (idx < n) begin
      bub = 1'b0;
      if (idx == gap_at && fixed_gaps < gap_len) begin
        bub = 1'b1;
        fixed_gaps++;
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        bub = 1'b1;
      end
      s_valid = !bub;
      s_a = DATA_W'(op_a[idx]);
      s_b = DATA_W'(op_b[idx]);
      start = mid_start && (idx == 1);
      len = (mid_start && idx == 1) ? LEN_W'(1) : LEN_W'(n);
      @(negedge CLK);
      check("s_ready_accum", s_ready, 1);
      check("dsp_a", dsp_a, last_a);
      check("dsp_b", dsp_b, last_b);
      @(posedge CLK); #1;
      cyc++;
      if (!bub) begin
        exp_ops.push_back(first ? 8'h01 : 8'h09);
        first = 1'b0;
        last_a = s_a;
        last_b = s_b;
        idx++;
      end else begin
        exp_ops.push_back(8'h08);
        bubbles++;
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 200 && timeout; k++) begin
      @(negedge CLK);
      if (m_valid === 1'b1) timeout = 1'b0;
      else begin
        @(posedge CLK); #1;
        cyc++;
      end
    end
    tracing = 1'b0;
    check("m_valid_timeout", timeout, 0);
    check("m_valid_cycle", cyc, n + bubbles + PIPE_LAT + 3);
    check("m_result", m_result, expv);
    check_str("opmode_seq", op_seq(op_trace), op_seq(exp_ops));
    repeat (hold) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check("hold_m_valid", m_valid, 1);
      check("hold_m_result", m_result, expv);
      check("hold_busy", busy, 1);
    end
    m_ready = 1'b1;
    @(posedge CLK); #1;
    m_ready = 1'b0;
    @(negedge CLK);
    check("idle_busy", busy, 0);
    check("idle_m_valid", m_valid, 0);
    check("idle_s_ready", s_ready, 0);
    $display("block len=%0d bubbles=%0d hold=%0d result=%012h latency=%0d",
             n, bubbles, hold, m_result, cyc);
  endtask

  initial begin
    logic signed [DATA_W-1:0] r;
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_s_ready", s_ready, 0);
    check("rst_dsp_a", dsp_a, 0);
    check("rst_dsp_b", dsp_b, 0);
    check("rst_opmode", dsp_opmode, 0);
    check("rst_ce", dsp_ce, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_result", m_result, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin op_a[i] = i + 1; op_b[i] = 2; end
    run_block(4, -1, 0, 0, 1'b0, 1'b0);

    op_a[0] = -3; op_b[0] = 5;
    run_block(1, -1, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin op_a[i] = i + 1; op_b[i] = 2; end
    run_block(4, 2, 2, 0, 1'b0, 1'b0);

    @(posedge CLK); #1;
    start = 1'b1;
    len = '0;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("len0_busy", busy, 0);
      check("len0_s_ready", s_ready, 0);
      @(posedge CLK); #1;
    end

    run_block(4, -1, 0, 0, 1'b0, 1'b1);
    run_block(4, -1, 0, 5, 1'b0, 1'b0);

    // Abort a block after two of four terms.
    @(posedge CLK); #1;
    start = 1'b1;
    len = LEN_W'(4);
    @(posedge CLK); #1;
    start = 1'b0;
    s_valid = 1'b1; s_a = DATA_W'(1); s_b = DATA_W'(2);
    @(posedge CLK); #1;
    s_a = DATA_W'(2);
    @(posedge CLK); #2;
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_s_ready", s_ready, 0);
    check("abort_dsp_a", dsp_a, 0);
    check("abort_dsp_b", dsp_b, 0);
    check("abort_opmode", dsp_opmode, 0);
    check("abort_ce", dsp_ce, 0);
    check("abort_m_valid", m_valid, 0);
    check("abort_m_result", m_result, 0);
    check("abort_busy", busy, 0);
    @(negedge CLK);
    rst = 1'b0;
    last_a = '0;
    last_b = '0;
    op_a[0] = 7; op_a[1] = 7; op_b[0] = 1; op_b[1] = 1;
    run_block(2, -1, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        r = DATA_W'($urandom); op_a[i] = int'(r);
        r = DATA_W'($urandom); op_b[i] = int'(r);
      end
      if (t == 0) begin op_a[0] = -131072; op_b[0] = -131072; end
      run_block(n, -1, 0, $urandom_range(0, 3), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
